uart_rx: RTL
============

# uart_rx

UART receiver that consumes the `tick_16x` oversampling strobe from `baudrate_gen` and turns the serial `rx` line into parallel bytes. It detects the start bit, samples each bit at mid-bit, and checks the stop bit. Each received word is presented on a valid/ready handshake to the downstream FIFO or register interface. It sits directly downstream of `baudrate_gen`, at the same level of the UART top.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame; legal range 5–9.
- `OVERSAMPLING`, 16: `tick_16x` pulses per bit. Must match `baudrate_gen`. Even, ≥ 8.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only when `UART_RX_PARITY_EN` is defined.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick_16x`  in  1  one-cycle oversampling strobe from `baudrate_gen`.
- `rx`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  DATA_BITS  received word, LSB received first.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid && rx_ready`.
- `busy`  out  1  a frame is being received (state ≠ IDLE).
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: a frame completed while `rx_valid` was high and not being consumed.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 when `UART_RX_PARITY_EN` is not defined.

## Operation
- `rx` passes through a 2-flop synchronizer, both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Counters:
  - `samp_cnt`: width $clog2(OVERSAMPLING). Increments only on `tick_16x`.
  - `bit_cnt`: width $clog2(DATA_BITS+1).
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - An `armed` flag sets when `rx_s==1`.
  - On `tick_16x` with `armed && rx_s==0`: go to START, set `samp_cnt=0`, clear `armed`.
  - Effect: after a framing error or break, the line must return high before a new start bit is accepted.
- START: on the tick where `samp_cnt==OVERSAMPLING/2-1` (mid start bit):
  - `rx_s==0`: go to DATA, `samp_cnt=0`, `bit_cnt=0`.
  - `rx_s==1`: false start; go to IDLE with no output and no error.
- DATA:
  - On the tick where `samp_cnt==OVERSAMPLING-1`, shift `rx_s` into the MSB of the shift register (LSB-first line order) and increment `bit_cnt`.
  - After `DATA_BITS` samples, go to PARITY (macro) or STOP.
  - `samp_cnt` wraps from OVERSAMPLING-1 to 0.
- STOP: sample at `samp_cnt==OVERSAMPLING-1`, then go to IDLE.
  - `rx_s==1` and parity OK: deliver the word.
  - `rx_s==0`: pulse `frame_err`; discard the word.
- Delivery:
  - If `rx_valid==0`, or `rx_valid && rx_ready` in the same cycle: load `rx_data`, set `rx_valid=1`.
  - Otherwise: pulse `overrun_err`. The old word is kept and the new word is dropped.
- `rx_valid` clears the cycle after `rx_valid && rx_ready`, unless a new word loads in that same cycle.
- Cycles without `tick_16x` hold all state; only the handshake logic advances.

## Timing
- Reset values:
  - Outputs: `rx_data=0`, `rx_valid=0`, `busy=0`, `frame_err=0`, `overrun_err=0`, `parity_err=0`.
  - Internal: state IDLE, `armed=0`, synchronizer = 1.
- Reset assertion mid-frame aborts immediately and drops the partial word. The first start bit is accepted only after `rx_s` is seen high.
- Input latency: 2 clk from `rx` to `rx_s`.
- Output timing:
  - `rx_valid` and the error pulses are registered. They assert on the clk cycle after the `tick_16x` that samples the stop bit.
  - End-to-end latency from the falling edge of the start bit ≈ (0.5 + DATA_BITS + P + 1) bit periods + 2–3 clk, where P=1 with parity, else 0. Start-detect uncertainty is 1/OVERSAMPLING bit.
- At most one error pulse per frame, with priority frame_err > parity_err > overrun_err.
- `busy` is high from the cycle after the start-detect tick until the cycle after the stop-sample tick.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in; one parity bit is sampled after the data bits, at mid-bit.
  - Parity is computed as XOR of the data bits and the received parity bit. It is expected to be 0 for even parity, 1 for odd parity (`PARITY_ODD`).
  - On mismatch: `parity_err` pulses and the word is discarded, even if the stop bit is good.
- Not defined: no PARITY state; frame is start + DATA_BITS + stop; `parity_err` tied 0.

## Test plan
Bench setup for all scenarios: 50 MHz `clk`, real `baudrate_gen` at 9600 baud (one bit = 5208 clk, `tick_16x` every 325 clk), `rx_ready=1` unless stated.
- **Single byte:** send 0xA5, 8N1 → `rx_data=0xA5`, `rx_valid` high for exactly 1 cycle; `rx_valid` rises 9.5 bit periods ±1/16 bit after the start edge; no error pulses.
- **Glitch rejection:** `rx` low for 4 `tick_16x` periods, then high → `rx_valid`, `busy` and all errors stay 0 after 2 `tick_16x`; a following 0x3C frame is received correctly.
- **Framing error:** send 0x55 with the stop bit driven 0, then hold low 2 bit times, then high → one `frame_err` pulse, no `rx_valid`. A new start bit during the low period is ignored; the next frame 0x12 is received after the line returns high.
- **Overrun:** `rx_ready=0`, send 0x11 then 0x22 back-to-back → `rx_valid=1`, `rx_data=0x11`, one `overrun_err` pulse at the end of the 0x22 frame. Then `rx_ready=1` for 1 cycle → `rx_valid` clears.
- **Reset mid-frame:** assert `rst_n=0` for 3 cycles during data bit 4 of 0xFF, resume the line idle → all outputs at reset values; the next frame 0x81 is received correctly.
- **Parity (macro on, `PARITY_ODD=0`):** 0x03 with parity bit 0 → `rx_data=0x03`. 0x03 with parity bit 1 → one `parity_err` pulse, no `rx_valid`.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver.
// Detects a start bit on the synchronized line, samples each data bit at
// mid-bit using the tick_16x strobe, checks the stop bit and hands the word
// to the consumer over a valid/ready handshake.
// Optional parity bit support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int SW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  // Reject parameter values the sampling scheme cannot support.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx: DATA_BITS must be in 5..9");
  end
  if (OVERSAMPLING < 8 || (OVERSAMPLING % 2) != 0) begin : g_bad_oversampling
    $error("uart_rx: OVERSAMPLING must be even and >= 8");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  logic                 rx_meta_q, rx_s_q;
  state_e               state_q, state_d;
  logic                 armed_q, armed_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD_BIT = 1'(PARITY_ODD);
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame state, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      armed_q       <= 1'b0;
      samp_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      samp_q        <= samp_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_q         <= par_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  // Next-state logic: frame sequencing on ticks, handshake on every cycle.
  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q;
    samp_d        = samp_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    data_d        = data_q;
    // A word taken by the consumer frees the output register next cycle.
    valid_d       = valid_q && !rx_ready;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d         = par_q;
    parity_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // The line must be seen high before a falling edge counts as a start.
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (tick_16x && armed_q) begin
          state_d = ST_START;
          samp_d  = '0;
          armed_d = 1'b0;
        end
      end

      ST_START: begin
        if (tick_16x) begin
          if (samp_q == SAMP_MID) begin
            if (!rx_s_q) begin
              state_d = ST_DATA;
              samp_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = ST_IDLE;  // glitch, not a real start bit
            end
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick_16x) begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_16x) begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            par_d   = rx_s_q;
            state_d = ST_STOP;
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
      end
`endif

      ST_STOP: begin
        if (tick_16x) begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            state_d = ST_IDLE;
            // Error priority: framing, then parity, then overrun.
            if (!rx_s_q) begin
              frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (((^shift_q) ^ par_q) != PAR_ODD_BIT) begin
              parity_err_d = 1'b1;
`endif
            end else if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_err_d = 1'b1;  // keep the unread word, drop the new one
            end
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
